// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven sequencing controller for a four-function
// keypad calculator. It owns the operand, memory and result registers,
// performs signed add/subtract with overflow detection, and exports the
// state code and display value.
module calc_sequencer #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] disp,
  output logic [WIDTH-1:0] mem,
  output logic             neg_op,
  output logic             err
);

  typedef enum logic [1:0] {
    RDY1 = 2'b00,
    OP   = 2'b01,
    RDY2 = 2'b11,
    RES  = 2'b10
  } state_t;

  localparam int CW = $clog2(MAX_DIGITS + 1);

  // Largest magnitude representable symmetrically; -2^(WIDTH-1) is rejected too
  localparam logic [WIDTH:0] LIMIT = {2'b00, {(WIDTH-1){1'b1}}};

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_PLUS  = 4'hC;
  localparam logic [3:0] KEY_EQ    = 4'hD;
  localparam logic [3:0] KEY_GETM  = 4'hE;
  localparam logic [3:0] KEY_SETM  = 4'hF;

  state_t           state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] mem_reg;
  logic [CW-1:0]    count_reg;
  logic             locked_reg;
  logic             neg_reg;
  logic             err_reg;
  logic             ready_reg;

  logic             accept;
  logic             is_digit;
  logic             can_append;
  logic             new_neg;
  logic [WIDTH-1:0] digit_ext;
  logic [WIDTH-1:0] entry_src;
  logic [WIDTH-1:0] appended;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] disp_sel;

  assign accept     = key_valid && ready_reg;
  assign is_digit   = (key_code <= 4'd9);
  assign can_append = (count_reg < CW'(MAX_DIGITS)) && !locked_reg;
  assign new_neg    = (key_code == KEY_MINUS);
  assign digit_ext  = {{(WIDTH-4){1'b0}}, key_code};

  // Digit entry appends to whichever operand is being typed
  assign entry_src = (state_reg == RDY2) ? op_b_reg : op_a_reg;
  assign appended  = entry_src * WIDTH'(10) + digit_ext;

  // Arithmetic one bit wider than the operands so overflow is visible
  assign a_ext = {op_a_reg[WIDTH-1], op_a_reg};
  assign b_ext = {op_b_reg[WIDTH-1], op_b_reg};
  assign sum   = neg_reg ? (a_ext - b_ext) : (a_ext + b_ext);
  assign ovf   = ($signed(sum) > $signed(LIMIT)) || ($signed(sum) < -$signed(LIMIT));
  assign sum_w = sum[WIDTH-1:0];

  // Display source follows the operand currently relevant to the user
  always_comb begin
    disp_sel = op_a_reg;
    case (state_reg)
      RDY2:    disp_sel = op_b_reg;
      RES:     disp_sel = result_reg;
      default: disp_sel = op_a_reg;
    endcase
  end

  assign key_ready = ready_reg;
  assign state     = state_reg;
  assign disp      = disp_sel;
  assign mem       = mem_reg;
  assign neg_op    = neg_reg;
  assign err       = err_reg;

  // Calculator state machine: handshake, key decode and register updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= RDY1;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      mem_reg    <= '0;
      count_reg  <= '0;
      locked_reg <= 1'b0;
      neg_reg    <= 1'b0;
      err_reg    <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      ready_reg <= !accept;
      if (accept) begin
        if (key_code == KEY_CLEAR) begin
          op_a_reg   <= '0;
          op_b_reg   <= '0;
          result_reg <= '0;
          count_reg  <= '0;
          locked_reg <= 1'b0;
          neg_reg    <= 1'b0;
          err_reg    <= 1'b0;
          state_reg  <= RDY1;
        end else if (!err_reg) begin
          if (is_digit) begin
            case (state_reg)
              RDY1: begin
                if (can_append) begin
                  op_a_reg  <= appended;
                  count_reg <= count_reg + CW'(1);
                end
              end
              OP: begin
                op_b_reg   <= digit_ext;
                count_reg  <= CW'(1);
                locked_reg <= 1'b0;
                state_reg  <= RDY2;
              end
              RDY2: begin
                if (can_append) begin
                  op_b_reg  <= appended;
                  count_reg <= count_reg + CW'(1);
                end
              end
              default: begin
                op_a_reg   <= digit_ext;
                count_reg  <= CW'(1);
                locked_reg <= 1'b0;
                state_reg  <= RDY1;
              end
            endcase
          end else begin
            case (key_code)
              KEY_MINUS, KEY_PLUS: begin
                case (state_reg)
                  RDY2: begin
                    // Chaining: fold the pending operation into opA first
                    if (ovf) begin
                      err_reg <= 1'b1;
                    end else begin
                      op_a_reg  <= sum_w;
                      neg_reg   <= new_neg;
                      state_reg <= OP;
                    end
                  end
                  RES: begin
                    op_a_reg  <= result_reg;
                    neg_reg   <= new_neg;
                    state_reg <= OP;
                  end
                  default: begin
                    neg_reg   <= new_neg;
                    state_reg <= OP;
                  end
                endcase
              end
              KEY_EQ: begin
                if (state_reg == RDY2) begin
                  if (ovf) begin
                    err_reg <= 1'b1;
                  end else begin
                    result_reg <= sum_w;
                    state_reg  <= RES;
                  end
                end
              end
              KEY_GETM: begin
                locked_reg <= 1'b1;
                if (state_reg == RDY1 || state_reg == RES) begin
                  op_a_reg  <= mem_reg;
                  state_reg <= RDY1;
                end else begin
                  op_b_reg  <= mem_reg;
                  state_reg <= RDY2;
                end
              end
              KEY_SETM: begin
                mem_reg <= disp_sel;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer. Each key press
// pushes the expected post-key outputs; a monitor pops and compares them
// on the cycle after the DUT accepts the key.
module tb_calc_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'h0;
  logic         key_ready;
  logic [1:0]   state;
  logic [W-1:0] disp;
  logic [W-1:0] mem;
  logic         neg_op;
  logic         err;

  typedef struct {
    logic [1:0]   st;
    logic [W-1:0] d;
    logic [W-1:0] m;
    logic         n;
    logic         e;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] exp_mem = '0;
  logic         exp_neg = 1'b0;
  logic         exp_err = 1'b0;

  calc_sequencer #(.WIDTH(W), .MAX_DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .state     (state),
    .disp      (disp),
    .mem       (mem),
    .neg_op    (neg_op),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Monitor: detect acceptance just before the edge, compare just after
  initial begin
    logic acc;
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      acc = key_valid && key_ready && rst_n;
      @(posedge clk);
      #1;
      if (acc) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected_accept got=key %h want=no accept", key_code);
        end else begin
          e = sb.pop_front();
          total++;
          if (state !== e.st) begin bad++; $display("FAIL sb_state got=%b want=%b", state, e.st); end
          total++;
          if (disp !== e.d) begin bad++; $display("FAIL sb_disp got=%0d want=%0d", $signed(disp), $signed(e.d)); end
          total++;
          if (mem !== e.m) begin bad++; $display("FAIL sb_mem got=%0d want=%0d", $signed(mem), $signed(e.m)); end
          total++;
          if (neg_op !== e.n) begin bad++; $display("FAIL sb_neg_op got=%b want=%b", neg_op, e.n); end
          total++;
          if (err !== e.e) begin bad++; $display("FAIL sb_err got=%b want=%b", err, e.e); end
          $display("key %h -> state=%b disp=%0d mem=%0d neg=%b err=%b",
                   key_code, state, $signed(disp), $signed(mem), neg_op, err);
        end
      end
    end
  end

  // Drive one key, wait for acceptance and check the one-cycle ready drop
  task automatic press(input logic [3:0] k, input logic [1:0] st, input logic [W-1:0] d);
    exp_t e;
    int n;
    e.st = st; e.d = d; e.m = exp_mem; e.n = exp_neg; e.e = exp_err;
    sb.push_back(e);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    n = 0;
    while (!key_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (key_ready !== 1'b1) begin
      bad++;
      $display("FAIL press_timeout got=key_ready %b want=1", key_ready);
      key_valid = 1'b0;
      sb.delete(sb.size() - 1);
      return;
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    total++;
    if (key_ready !== 1'b0) begin bad++; $display("FAIL ready_low got=%b want=0", key_ready); end
    @(posedge clk);
    #1;
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL ready_high got=%b want=1", key_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", state); end
    total++;
    if (disp !== '0) begin bad++; $display("FAIL reset_disp got=%0d want=0", disp); end
    total++;
    if (mem !== '0) begin bad++; $display("FAIL reset_mem got=%0d want=0", mem); end
    total++;
    if (key_ready !== 1'b1 || neg_op !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=rdy%b neg%b err%b want=rdy1 neg0 err0", key_ready, neg_op, err);
    end
    $display("reset: state=%b disp=%0d mem=%0d ready=%b", state, disp, mem, key_ready);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    exp_mem = '0; exp_neg = 1'b0; exp_err = 1'b0;
    press(4'd1, 2'b00, 16'd1);
    press(4'd2, 2'b00, 16'd12);
    press(4'hC, 2'b01, 16'd12);
    press(4'd3, 2'b11, 16'd3);
    press(4'd4, 2'b11, 16'd34);
    press(4'hD, 2'b10, 16'd46);
  endtask

  task automatic test_sub();
    press(4'd5, 2'b00, 16'd5);
    exp_neg = 1'b1;
    press(4'hB, 2'b01, 16'd5);
    press(4'd9, 2'b11, 16'd9);
    press(4'hD, 2'b10, 16'hFFFC);
    total++;
    if (neg_op !== 1'b1) begin bad++; $display("FAIL sub_neg got=%b want=1", neg_op); end
  endtask

  task automatic test_chain();
    press(4'd1, 2'b00, 16'd1);
    exp_neg = 1'b0;
    press(4'hC, 2'b01, 16'd1);
    press(4'd2, 2'b11, 16'd2);
    exp_neg = 1'b1;
    press(4'hB, 2'b01, 16'd3);
    press(4'd4, 2'b11, 16'd4);
    press(4'hD, 2'b10, 16'hFFFF);
  endtask

  task automatic test_digits_mem();
    press(4'd1, 2'b00, 16'd1);
    press(4'd2, 2'b00, 16'd12);
    press(4'd3, 2'b00, 16'd123);
    press(4'd4, 2'b00, 16'd1234);
    press(4'd5, 2'b00, 16'd1234);
    exp_mem = 16'd1234;
    press(4'hF, 2'b00, 16'd1234);
    exp_neg = 1'b0;
    press(4'hA, 2'b00, 16'd0);
    press(4'hE, 2'b00, 16'd1234);
    press(4'd7, 2'b00, 16'd1234);
    press(4'hC, 2'b01, 16'd1234);
    press(4'hE, 2'b11, 16'd1234);
    press(4'd8, 2'b11, 16'd1234);
    press(4'hD, 2'b10, 16'd2468);
  endtask

  task automatic test_overflow();
    press(4'hA, 2'b00, 16'd0);
    press(4'd9, 2'b00, 16'd9);
    press(4'd9, 2'b00, 16'd99);
    press(4'd9, 2'b00, 16'd999);
    press(4'd9, 2'b00, 16'd9999);
    exp_mem = 16'd9999;
    press(4'hF, 2'b00, 16'd9999);
    press(4'hE, 2'b00, 16'd9999);
    press(4'hC, 2'b01, 16'd9999);
    press(4'hE, 2'b11, 16'd9999);
    press(4'hC, 2'b01, 16'd19998);
    press(4'hE, 2'b11, 16'd9999);
    press(4'hC, 2'b01, 16'd29997);
    press(4'hE, 2'b11, 16'd9999);
    exp_err = 1'b1;
    press(4'hC, 2'b11, 16'd9999);
    press(4'd5, 2'b11, 16'd9999);
    press(4'hD, 2'b11, 16'd9999);
    press(4'hF, 2'b11, 16'd9999);
    press(4'hB, 2'b11, 16'd9999);
    exp_err = 1'b0;
    press(4'hA, 2'b00, 16'd0);
  endtask

  task automatic test_held_key();
    exp_t e;
    e.st = 2'b00; e.d = 16'd7; e.m = exp_mem; e.n = exp_neg; e.e = exp_err;
    sb.push_back(e);
    e.d = 16'd77;
    sb.push_back(e);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd7;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    total++;
    if (disp !== 16'd77) begin bad++; $display("FAIL held_disp got=%0d want=77", disp); end
    @(posedge clk);
    #1;
    total++;
    if (disp !== 16'd77) begin bad++; $display("FAIL held_stop got=%0d want=77", disp); end
  endtask

  task automatic test_reset_mid();
    press(4'hA, 2'b00, 16'd0);
    press(4'd5, 2'b00, 16'd5);
    press(4'hC, 2'b01, 16'd5);
    press(4'd5, 2'b11, 16'd5);
    press(4'd6, 2'b11, 16'd56);
    @(negedge clk);
    rst_n     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'd7;
    @(posedge clk);
    #1;
    total++;
    if (state !== 2'b00) begin bad++; $display("FAIL midrst_state got=%b want=00", state); end
    total++;
    if (disp !== '0) begin bad++; $display("FAIL midrst_disp got=%0d want=0", disp); end
    total++;
    if (mem !== '0) begin bad++; $display("FAIL midrst_mem got=%0d want=0", mem); end
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", key_ready); end
    $display("mid-entry reset: state=%b disp=%0d mem=%0d ready=%b", state, disp, mem, key_ready);
    @(negedge clk);
    key_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (disp !== '0 || state !== 2'b00) begin
      bad++; $display("FAIL midrst_after got=state %b disp %0d want=state 00 disp 0", state, disp);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_chain();
    test_digits_mem();
    test_overflow();
    test_held_key();
    test_reset_mid();
    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Sequencing controller for the four-function keypad calculator. It accepts decoded key strobes from the keypad scanner and walks the calculator state machine (first operand, operator, second operand, result). It owns the operand, memory and result registers, and performs add/subtract. It exports the 2-bit state code and the value for the display path.

Parameters:
WIDTH, 16, signed two's-complement width of operands, memory and result.
MAX_DIGITS, 4, maximum decimal digits accepted per typed operand.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
key_valid  input  1  key present; held until accepted
key_code  input  4  0-9 digit, A clear, B minus, C plus, D equals, E getM (#), F setM (*)
key_ready  output  1  block can accept a key this cycle
state  output  2  00 RDY1, 01 OP, 11 RDY2, 10 RES
disp  output  WIDTH  signed value to display
mem  output  WIDTH  memory register contents
neg_op  output  1  latched operator: 1 = minus, 0 = plus
err  output  1  arithmetic overflow; latched until clear

Behaviour:
- Reset (rst_n=0 at clk edge): state=RDY1; opA, opB, result and mem = 0; digit count=0; neg_op=0; err=0; key_ready=1. Reset wins over any key in the same cycle.
- Handshake: a key is accepted when key_valid && key_ready at a clock edge. key_ready is 0 for exactly the one cycle after an accepted key, and 1 otherwise. All register and state effects are visible the cycle after acceptance.
- Digit d, by state:
  - RDY1: if count<MAX_DIGITS and digits are not locked, opA=opA*10+d and count++. Otherwise ignored.
  - OP: opB=d, count=1, go to RDY2.
  - RDY2: same append rule as RDY1, applied to opB.
  - RES: opA=d, count=1, go to RDY1.
- B/C (operator), by state:
  - RDY1 or OP: latch neg_op and go to OP (re-pressing in OP replaces the operator).
  - RDY2: compute r = opA±opB, then opA=r, latch the new operator, go to OP (chaining).
  - RES: opA=result, latch operator, go to OP.
- D (equals):
  - RDY2: result=opA±opB, go to RES.
  - Any other state: ignored.
- E (getM):
  - RDY1 or RES: opA=mem, digits locked, go to RDY1.
  - OP or RDY2: opB=mem, digits locked, go to RDY2.
  - A locked operand ignores further digits until a new operand starts.
- F (setM): mem=disp. State unchanged.
- A (clear): opA=opB=result=0, count=0, neg_op=0, err=0, go to RDY1. mem is preserved.
- disp selection: RDY1/OP show opA, RDY2 shows opB, RES shows result.
- Arithmetic is computed in WIDTH+1 bits. If the true value is outside ±(2^(WIDTH-1)-1):
  - err=1, and all destination registers and state are left unchanged.
  - While err=1, every key except A is accepted (handshake completes) but has no effect.
- Digit append: with MAX_DIGITS=4 and WIDTH=16 an entered operand is at most 9999, so append never overflows.
- key_valid held high after acceptance: the same key is accepted again on the first cycle key_ready returns to 1. The scanner must drop key_valid in the cycle after acceptance.

Test Plan:
- Reset, then keys 1,2,C,3,4,D -> state 00,00,01,11,11,10; disp=12 then 34; result disp=46; key_ready low one cycle after each key.
- 5,B,9,D -> disp=-4 (0xFFFC), neg_op=1, state=10.
- 1,C,2,B,4,D -> after B disp=3 (chained) and state=01; final disp=-1.
- 1,2,3,4,5 -> fifth digit ignored, disp=1234. Then F sets mem=1234; A clears disp=0 with mem=1234 kept; E then C,E,D gives disp=2468.
- Overflow: load mem=9999, then E,C,E repeated via chaining (E,C,E,C...). When the sum exceeds 32767, err=1 and disp holds its last valid value. Digit keys have no effect while err=1; A clears err and sets state=00.
- Reset asserted mid-entry (state 11, opB=56) while key_valid=1 -> next cycle state=00, disp=0, mem=0, key_ready=1, and the pending key is not applied.
